// File: rtl/op_controller_pkg.sv
// Shared opcode and argument-count definitions for the RPN operator path.
package op_controller_pkg;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_MUL     = 4'd2;
  localparam logic [3:0] OP_DIV     = 4'd3;
  localparam logic [3:0] OP_POP     = 4'd4;
  localparam logic [3:0] OP_UNKNOWN = 4'd15;

  // Stack depth each operator class needs before it can run.
  localparam logic [1:0] ARGS_BINARY = 2'd2;
  localparam logic [1:0] ARGS_POP    = 2'd1;

  // The four arithmetic opcodes map directly onto the low two opcode bits.
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_e;

endpackage

// File: rtl/op_controller_alu.sv
// Combinational unsigned ALU computing "b a op" in RPN order, modulo 2^WIDTH.
module op_alu
  import op_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_e          alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             div_zero
);

  logic [WIDTH-1:0] divisor;

  // Divide by a forced-nonzero divisor so the quantity stays defined; the
  // controller rejects the operation via div_zero anyway.
  always_comb begin
    div_zero = (a == '0);
    divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : a;
    y        = '0;
    unique case (alu_op)
      ALU_ADD: y = b + a;
      ALU_SUB: y = b - a;
      ALU_MUL: y = b * a;
      ALU_DIV: y = b / divisor;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/op_controller.sv
// Operator sequencer: validates an operator against stack depth, computes
// the result and reports pop count plus push/print/error pulses one cycle later.
module op_controller
  import op_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_en,
  input  logic [3:0]       op,
  input  logic [1:0]       arg_cnt,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic [1:0]       pop_cnt,
  output logic             ans_ready,
  output logic             print_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  logic [WIDTH-1:0] alu_y;
  logic             alu_div_zero;
  logic [1:0]       pop_cnt_nxt;
  logic             ans_ready_nxt;
  logic             print_ready_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] result_nxt;

  op_alu #(.WIDTH(WIDTH)) u_alu (
    .alu_op   (alu_op_e'(op[1:0])),
    .a        (opnd_a),
    .b        (opnd_b),
    .y        (alu_y),
    .div_zero (alu_div_zero)
  );

  // Decide this cycle's response; result holds unless a push or print occurs.
  always_comb begin
    pop_cnt_nxt     = 2'd0;
    ans_ready_nxt   = 1'b0;
    print_ready_nxt = 1'b0;
    err_nxt         = 1'b0;
    result_nxt      = result;
    if (op_en) begin
      case (op)
        OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
          if (arg_cnt < ARGS_BINARY || (op == OP_DIV && alu_div_zero)) begin
            err_nxt = 1'b1;
          end else begin
            pop_cnt_nxt   = 2'd2;
            ans_ready_nxt = 1'b1;
            result_nxt    = alu_y;
          end
        end
        OP_POP: begin
          if (arg_cnt < ARGS_POP) begin
            err_nxt = 1'b1;
          end else begin
            pop_cnt_nxt     = 2'd1;
            print_ready_nxt = 1'b1;
            result_nxt      = opnd_a;
          end
        end
        default: err_nxt = 1'b1;
      endcase
    end
  end

  // Register all outputs; reset wins over a simultaneous operator strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt     <= 2'd0;
      ans_ready   <= 1'b0;
      print_ready <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
    end else begin
      pop_cnt     <= pop_cnt_nxt;
      ans_ready   <= ans_ready_nxt;
      print_ready <= print_ready_nxt;
      err         <= err_nxt;
      result      <= result_nxt;
    end
  end

endmodule

// File: tb/tb_op_controller.sv
// Self-checking bench for op_controller: directed scenarios plus randomized
// operators compared against a behavioural model of the calculator rules.
module tb_op_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_en;
  logic [3:0]  op;
  logic [1:0]  arg_cnt;
  logic [15:0] opnd_a;
  logic [15:0] opnd_b;
  logic [1:0]  pop_cnt;
  logic        ans_ready;
  logic        print_ready;
  logic [15:0] result;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  // Model state: expected outputs after the most recent edge.
  logic [1:0]  m_pop;
  logic        m_ans, m_print, m_err;
  logic [15:0] m_result = 16'd0;

  op_controller #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_en       (op_en),
    .op          (op),
    .arg_cnt     (arg_cnt),
    .opnd_a      (opnd_a),
    .opnd_b      (opnd_b),
    .pop_cnt     (pop_cnt),
    .ans_ready   (ans_ready),
    .print_ready (print_ready),
    .result      (result),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] observed();
    return {pop_cnt, ans_ready, print_ready, err, result};
  endfunction

  // Behavioural model of one edge, written from the calculator rules.
  task automatic model_step(input logic r, input logic en, input int o,
                            input int cnt, input longint a, input longint b);
    int need;
    m_pop = 0; m_ans = 0; m_print = 0; m_err = 0;
    if (r) begin
      m_result = 0;
      return;
    end
    if (!en) return;
    need = (o <= 3) ? 2 : (o == 4) ? 1 : 99;
    if (cnt < need || (o == 3 && a == 0)) begin
      m_err = 1;
    end else if (o == 4) begin
      m_pop = 1; m_print = 1; m_result = 16'(a);
    end else begin
      m_pop = 2; m_ans = 1;
      case (o)
        0: m_result = 16'((b + a) % 65536);
        1: m_result = 16'((b - a + 65536) % 65536);
        2: m_result = 16'((b * a) % 65536);
        default: m_result = 16'(b / a);
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic applyStep(input logic r, input logic en, input logic [3:0] o,
                           input logic [1:0] cnt, input logic [15:0] a,
                           input logic [15:0] b);
    rst = r; op_en = en; op = o; arg_cnt = cnt; opnd_a = a; opnd_b = b;
    model_step(r, en, int'(o), int'(cnt), longint'(a), longint'(b));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStep(1'b1, 1'b1, 4'd0, 2'd3, 16'd7, 16'd9);
      vectors++;
      if (observed() !== 21'd0) begin
        miscompares++;
        $display("[TB] FAIL reset cycle %0d: got %h want %h", i, observed(), 21'd0);
      end
    end
  endtask

  task automatic test_add();
    applyStep(1'b0, 1'b1, 4'd0, 2'd2, 16'd3, 16'd5);
    vectors++;
    if (observed() !== {2'd2, 1'b1, 1'b0, 1'b0, 16'd8}) begin
      miscompares++;
      $display("[TB] FAIL add: got %h want %h", observed(), {2'd2, 3'b100, 16'd8});
    end
    applyStep(1'b0, 1'b0, 4'd0, 2'd2, 16'd1, 16'd1);
    vectors++;
    if (observed() !== {2'd0, 3'b000, 16'd8}) begin
      miscompares++;
      $display("[TB] FAIL add_idle: got %h want %h", observed(), {2'd0, 3'b000, 16'd8});
    end
  endtask

  task automatic test_pop();
    applyStep(1'b0, 1'b1, 4'd4, 2'd2, 16'd42, 16'd99);
    vectors++;
    if (observed() !== {2'd1, 1'b0, 1'b1, 1'b0, 16'd42}) begin
      miscompares++;
      $display("[TB] FAIL pop: got %h want %h", observed(), {2'd1, 3'b010, 16'd42});
    end
  endtask

  task automatic test_sub();
    applyStep(1'b0, 1'b1, 4'd1, 2'd2, 16'd5, 16'd3);
    vectors++;
    if (observed() !== {2'd2, 3'b100, 16'hFFFE}) begin
      miscompares++;
      $display("[TB] FAIL sub_wrap: got %h want %h", observed(), {2'd2, 3'b100, 16'hFFFE});
    end
  endtask

  task automatic test_errors();
    // Divide by zero, too few args for MUL, unknown opcode; result must hold.
    applyStep(1'b0, 1'b1, 4'd3, 2'd2, 16'd0, 16'd10);
    vectors++;
    if (observed() !== {2'd0, 3'b001, 16'hFFFE}) begin
      miscompares++;
      $display("[TB] FAIL div_zero: got %h want %h", observed(), {2'd0, 3'b001, 16'hFFFE});
    end
    applyStep(1'b0, 1'b1, 4'd2, 2'd1, 16'd4, 16'd6);
    vectors++;
    if (observed() !== {2'd0, 3'b001, 16'hFFFE}) begin
      miscompares++;
      $display("[TB] FAIL mul_args: got %h want %h", observed(), {2'd0, 3'b001, 16'hFFFE});
    end
    applyStep(1'b0, 1'b1, 4'd15, 2'd3, 16'd4, 16'd6);
    vectors++;
    if (observed() !== {2'd0, 3'b001, 16'hFFFE}) begin
      miscompares++;
      $display("[TB] FAIL unknown_op: got %h want %h", observed(), {2'd0, 3'b001, 16'hFFFE});
    end
    applyStep(1'b0, 1'b1, 4'd4, 2'd0, 16'd4, 16'd6);
    vectors++;
    if (observed() !== {2'd0, 3'b001, 16'hFFFE}) begin
      miscompares++;
      $display("[TB] FAIL pop_empty: got %h want %h", observed(), {2'd0, 3'b001, 16'hFFFE});
    end
  endtask

  task automatic test_back_to_back();
    applyStep(1'b0, 1'b1, 4'd0, 2'd3, 16'd10, 16'd20);
    vectors++;
    if (observed() !== {2'd2, 3'b100, 16'd30}) begin
      miscompares++;
      $display("[TB] FAIL b2b_add: got %h want %h", observed(), {2'd2, 3'b100, 16'd30});
    end
    applyStep(1'b0, 1'b1, 4'd4, 2'd1, 16'd7, 16'd0);
    vectors++;
    if (observed() !== {2'd1, 3'b010, 16'd7}) begin
      miscompares++;
      $display("[TB] FAIL b2b_pop: got %h want %h", observed(), {2'd1, 3'b010, 16'd7});
    end
    applyStep(1'b0, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0);
    vectors++;
    if (observed() !== {2'd0, 3'b000, 16'd7}) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle: got %h want %h", observed(), {2'd0, 3'b000, 16'd7});
    end
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [15:0] a, b;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        6:       o = 4'd15;
        7:       o = 4'($urandom_range(5, 15));
        default: o = 4'($urandom_range(0, 4));
      endcase
      a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      applyStep(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), o,
                2'($urandom_range(0, 3)), a, b);
      vectors++;
      if (observed() !== {m_pop, m_ans, m_print, m_err, m_result}) begin
        miscompares++;
        $display("[TB] FAIL random %0d op=%0d cnt=%0d a=%h b=%h: got %h want %h",
                 i, op, arg_cnt, opnd_a, opnd_b, observed(),
                 {m_pop, m_ans, m_print, m_err, m_result});
      end
    end
  endtask

  initial begin
    rst = 1'b1; op_en = 1'b0; op = 4'd0; arg_cnt = 2'd0; opnd_a = 16'd0; opnd_b = 16'd0;
    test_reset();
    test_add();
    test_pop();
    test_sub();
    test_errors();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
